// File: rtl/m68k_region_decoder_if.sv
// Bus bundle between a 68000 CPU and its region decoder.
// The CPU side (master) drives address, strobe, direction and the region
// enables. The decoder side (slave) returns the chip selects and the bus
// termination signals.
interface m68k_region_decoder_if #(
    parameter int ADDR_W = 24,
    parameter int N_REG  = 32
);
    logic [ADDR_W-1:0] cpu_a;
    logic              cpu_as_n;
    logic              cpu_rw;
    logic [N_REG-1:0]  region_en;
    logic [N_REG-1:0]  cs;
    logic [5:0]        hit_idx;
    logic              miss;
    logic              dtack_n;
    logic              berr_n;

    modport master (
        output cpu_a, cpu_as_n, cpu_rw, region_en,
        input  cs, hit_idx, miss, dtack_n, berr_n
    );

    modport slave (
        input  cpu_a, cpu_as_n, cpu_rw, region_en,
        output cs, hit_idx, miss, dtack_n, berr_n
    );
endinterface

// File: rtl/m68k_region_decoder.sv
// Registered address decoder and bus-cycle controller for a 68000 bus.
// Each region is a start/end window on the low DEC_BITS address bits, so
// higher address bits mirror. The lowest-numbered hitting region wins. A hit
// is acknowledged with DTACK after the region's wait states; an unmapped
// access ends in BERR after TIMEOUT cycles, or in DTACK with an open bus
// when TIMEOUT is 0.
module m68k_region_decoder #(
    parameter int                      N_REG       = 32,
    parameter int                      ADDR_W      = 24,
    parameter int                      DEC_BITS    = 20,
    parameter logic [N_REG*ADDR_W-1:0] REG_START   = '0,
    parameter logic [N_REG*ADDR_W-1:0] REG_END     = '0,
    parameter logic [N_REG*4-1:0]      WAIT_STATES = '0,
    parameter logic [N_REG-1:0]        RD_ONLY     = '0,
    parameter int                      TIMEOUT     = 16
) (
    input logic                   clk,
    input logic                   reset,
    m68k_region_decoder_if.slave  bus
);

    // The counter must hold both a 4-bit wait-state count and the timeout.
    localparam int TO_W     = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam int CNT_W    = (TO_W > 4) ? TO_W : 4;
    localparam bit OPEN_BUS = (TIMEOUT == 0);

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        ACK,
        ERR
    } state_t;

    state_t             state;
    logic [CNT_W-1:0]   counter;
    logic [N_REG-1:0]   cs_q;
    logic [5:0]         hit_idx_q;
    logic               miss_q;
    logic               dtack_n_q;
    logic               berr_n_q;

    logic [N_REG-1:0]   hit_vec;
    logic [N_REG-1:0]   dec_cs;
    logic [5:0]         dec_idx;
    logic               dec_hit;
    logic [3:0]         dec_ws;
    logic [DEC_BITS-1:0] dec_a;

    assign dec_a = bus.cpu_a[DEC_BITS-1:0];

    // Address bits above DEC_BITS are ignored, which is what makes mirrors.
    generate
        if (DEC_BITS < ADDR_W) begin : g_mirror
            logic unused_hi;
            assign unused_hi = ^bus.cpu_a[ADDR_W-1:DEC_BITS];
        end
    endgenerate

    // Per-region window compare on the live address.
    always_comb begin
        // NOTE: every combinational output gets a default before any
        // conditional assignment, so no path leaves it holding a value (latch).
        hit_vec = '0;
        for (int i = 0; i < N_REG; i++) begin
            hit_vec[i] = bus.region_en[i]
                       && (dec_a >= REG_START[i*ADDR_W +: DEC_BITS])
                       && (dec_a <= REG_END[i*ADDR_W +: DEC_BITS])
                       && (!RD_ONLY[i] || bus.cpu_rw);
        end
    end

    // Priority select: scanning from the top down leaves the lowest hit last.
    always_comb begin
        dec_cs  = '0;
        dec_idx = '0;
        dec_hit = 1'b0;
        dec_ws  = '0;
        for (int i = N_REG - 1; i >= 0; i--) begin
            if (hit_vec[i]) begin
                dec_cs    = '0;
                dec_cs[i] = 1'b1;
                dec_idx   = 6'(i);
                dec_hit   = 1'b1;
                dec_ws    = WAIT_STATES[i*4 +: 4];
            end
        end
    end

    // Bus-cycle FSM: latch the decode at the start of a cycle, count waits,
    // then terminate with DTACK or BERR until the strobe is released.
    always_ff @(posedge clk or posedge reset) begin
        // NOTE: state registers use non-blocking assignments so every register
        // updates from pre-edge values, independent of statement order.
        if (reset) begin
            state     <= IDLE;
            counter   <= '0;
            cs_q      <= '0;
            hit_idx_q <= '0;
            miss_q    <= 1'b0;
            dtack_n_q <= 1'b1;
            berr_n_q  <= 1'b1;
        end else if (bus.cpu_as_n) begin
            // Strobe released (normally or as an abort): end the cycle.
            state     <= IDLE;
            counter   <= '0;
            cs_q      <= '0;
            hit_idx_q <= '0;
            miss_q    <= 1'b0;
            dtack_n_q <= 1'b1;
            berr_n_q  <= 1'b1;
        end else begin
            case (state)
                IDLE: begin
                    cs_q      <= dec_cs;
                    hit_idx_q <= dec_idx;
                    miss_q    <= !dec_hit;
                    counter   <= dec_hit ? CNT_W'(dec_ws) : CNT_W'(TIMEOUT);
                    state     <= WAIT;
                end
                WAIT: begin
                    if (!miss_q || OPEN_BUS) begin
                        if (counter == '0) begin
                            dtack_n_q <= 1'b0;
                            state     <= ACK;
                        end else begin
                            counter <= counter - 1'b1;
                        end
                    end else begin
                        if (counter == CNT_W'(1)) begin
                            berr_n_q <= 1'b0;
                            state    <= ERR;
                        end else if (counter != '0) begin
                            counter <= counter - 1'b1;
                        end
                    end
                end
                ACK, ERR: begin
                    state <= state;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    assign bus.cs      = cs_q;
    assign bus.hit_idx = hit_idx_q;
    assign bus.miss    = miss_q;
    assign bus.dtack_n = dtack_n_q;
    assign bus.berr_n  = berr_n_q;

endmodule
